// File: rtl/ldq_pkg.sv
// Shared FP32 definitions for the linear dequantiser pipeline:
// field widths, special encodings and the per-lane operand classifier.
package ldq_pkg;

  localparam int MAN_W = 23;
  localparam int EXP_W = 8;

  localparam logic [9:0]       EXP_BIAS = 10'd127;
  localparam logic [EXP_W-1:0] EXP_MAX  = 8'd255;
  localparam logic [MAN_W-1:0] QNAN_MAN = 23'h400000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [1:0] {
    K_NORM = 2'd0,
    K_ZERO = 2'd1,
    K_INF  = 2'd2,
    K_NAN  = 2'd3
  } kind_e;

  localparam fp32_t FP32_ONE = {1'b0, 8'd127, 23'd0};

  // Special-case priority: NaN (incl. inf x zero), then inf, then zero (denormals flush).
  function automatic kind_e classify(fp32_t a, fp32_t b);
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    a_nan  = (a.expo == EXP_MAX) && (a.man != 23'd0);
    b_nan  = (b.expo == EXP_MAX) && (b.man != 23'd0);
    a_inf  = (a.expo == EXP_MAX) && (a.man == 23'd0);
    b_inf  = (b.expo == EXP_MAX) && (b.man == 23'd0);
    a_zero = (a.expo == 8'd0);
    b_zero = (b.expo == 8'd0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      return K_NAN;
    end else if (a_inf || b_inf) begin
      return K_INF;
    end else if (a_zero || b_zero) begin
      return K_ZERO;
    end else begin
      return K_NORM;
    end
  endfunction

endpackage

// File: rtl/ldq_fp32_mul_lane.sv
// One FP32 lane of the dequantiser: S1 classify + multiply, S2 normalise,
// S3 pack into the output register. All stages shift together on adv_i.
module ldq_fp32_mul_lane
  import ldq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        adv_i,
  input  logic        mode_i,
  input  logic        a_sign_i,
  input  logic [7:0]  a_exp_i,
  input  logic [22:0] a_man_i,
  input  logic        b_sign_i,
  input  logic [7:0]  b_exp_i,
  input  logic [22:0] b_man_i,
  output logic        res_sign_o,
  output logic [7:0]  res_exp_o,
  output logic [22:0] res_man_o,
  output logic        ovf_o,
  output logic        unf_o
);

  fp32_t       a_s, b_s;
  logic [47:0] prod_s;
  logic        prod_unused_s;

  assign a_s    = {a_sign_i, a_exp_i, a_man_i};
  assign b_s    = {b_sign_i, b_exp_i, b_man_i};
  assign prod_s = 48'({1'b1, a_man_i}) * 48'({1'b1, b_man_i});
  // Low product bits are truncated away (round toward zero).
  assign prod_unused_s = ^prod_s[22:0];

  logic        mode1_q, sign1_q;
  fp32_t       a1_q;
  kind_e       kind1_q;
  logic [24:0] prod1_q;
  logic [9:0]  esum1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode1_q <= 1'b0;
      sign1_q <= 1'b0;
      a1_q    <= fp32_t'(32'd0);
      kind1_q <= K_NORM;
      prod1_q <= 25'd0;
      esum1_q <= 10'd0;
    end else if (adv_i) begin
      mode1_q <= mode_i;
      sign1_q <= a_sign_i ^ b_sign_i;
      a1_q    <= a_s;
      kind1_q <= classify(a_s, b_s);
      prod1_q <= prod_s[47:23];
      esum1_q <= {2'b00, a_exp_i} + {2'b00, b_exp_i};
    end
  end

  logic [22:0] man2_d;
  logic [9:0]  exp2_d;

  always_comb begin
    man2_d = prod1_q[22:0];
    exp2_d = esum1_q - EXP_BIAS;
    if (prod1_q[24]) begin
      man2_d = prod1_q[23:1];
      exp2_d = esum1_q - (EXP_BIAS - 10'd1);
    end else begin
      man2_d = prod1_q[22:0];
      exp2_d = esum1_q - EXP_BIAS;
    end
  end

  logic               mode2_q, sign2_q;
  fp32_t              a2_q;
  kind_e              kind2_q;
  logic [22:0]        man2_q;
  logic signed [9:0]  exp2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode2_q <= 1'b0;
      sign2_q <= 1'b0;
      a2_q    <= fp32_t'(32'd0);
      kind2_q <= K_NORM;
      man2_q  <= 23'd0;
      exp2_q  <= 10'sd0;
    end else if (adv_i) begin
      mode2_q <= mode1_q;
      sign2_q <= sign1_q;
      a2_q    <= a1_q;
      kind2_q <= kind1_q;
      man2_q  <= man2_d;
      exp2_q  <= $signed(exp2_d);
    end
  end

  logic  ovf_s, unf_s;
  fp32_t res3_d, res3_q;

  assign ovf_s = !mode2_q && (kind2_q == K_NORM) && (exp2_q >= 10'sd255);
  assign unf_s = !mode2_q && (kind2_q == K_NORM) && (exp2_q <= 10'sd0);

  always_comb begin
    res3_d = a2_q;
    if (mode2_q) begin
      res3_d = a2_q;
    end else begin
      case (kind2_q)
        K_NAN:   res3_d = {1'b0, EXP_MAX, QNAN_MAN};
        K_INF:   res3_d = {sign2_q, EXP_MAX, 23'd0};
        K_ZERO:  res3_d = {sign2_q, 8'd0, 23'd0};
        default: begin
          if (ovf_s) begin
            res3_d = {sign2_q, EXP_MAX, 23'd0};
          end else if (unf_s) begin
            res3_d = {sign2_q, 8'd0, 23'd0};
          end else begin
            res3_d = {sign2_q, exp2_q[7:0], man2_q};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res3_q <= fp32_t'(32'd0);
    end else if (adv_i) begin
      res3_q <= res3_d;
    end
  end

  assign res_sign_o = res3_q.sign;
  assign res_exp_o  = res3_q.expo;
  assign res_man_o  = res3_q.man;
  assign ovf_o      = ovf_s;
  assign unf_o      = unf_s;

endmodule

// File: rtl/linear_dequant_pipe.sv
// LANES-wide FP32 scale multiplier with valid/ready handshake, bypass mode,
// sticky overflow/underflow flags and an accepted-beat counter.
module linear_dequant_pipe
  import ldq_pkg::*;
#(
  parameter int LANES = 8,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 scale_wr,
  input  logic [22:0]          scale_man,
  input  logic [7:0]           scale_exp,
  input  logic                 scale_sign,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [LANES*23-1:0]  src_man,
  input  logic [LANES*8-1:0]   src_exp,
  input  logic [LANES-1:0]     src_sign,
  output logic                 dst_valid,
  input  logic                 dst_ready,
  output logic [LANES*23-1:0]  dst_man,
  output logic [LANES*8-1:0]   dst_exp,
  output logic [LANES-1:0]     dst_sign,
  input  logic                 clr_flags,
  output logic                 ovf_flag,
  output logic                 unf_flag,
  output logic [CNT_W-1:0]     beat_cnt
);

  fp32_t            scale_q;
  logic             v1_q, v2_q, v3_q;
  logic             adv_s;
  logic [LANES-1:0] lane_ovf_s, lane_unf_s;
  logic             ovf_q, unf_q;
  logic [CNT_W-1:0] cnt_q;

  // Bubbles are not collapsed: the whole pipe moves or holds as one.
  assign adv_s     = !v3_q || dst_ready;
  assign src_ready = adv_s;
  assign dst_valid = v3_q;
  assign ovf_flag  = ovf_q;
  assign unf_flag  = unf_q;
  assign beat_cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scale_q <= FP32_ONE;
    end else if (scale_wr) begin
      scale_q <= {scale_sign, scale_exp, scale_man};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (adv_s) begin
      v1_q <= src_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_flags) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      cnt_q <= CNT_W'(0);
    end else begin
      if (adv_s && v2_q) begin
        ovf_q <= ovf_q | (|lane_ovf_s);
        unf_q <= unf_q | (|lane_unf_s);
      end
      if (src_valid && adv_s) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ldq_fp32_mul_lane u_lane (
      .clk_i      (clk),
      .rst_i      (rst),
      .adv_i      (adv_s),
      .mode_i     (mode),
      .a_sign_i   (src_sign[i]),
      .a_exp_i    (src_exp[i*8 +: 8]),
      .a_man_i    (src_man[i*23 +: 23]),
      .b_sign_i   (scale_q.sign),
      .b_exp_i    (scale_q.expo),
      .b_man_i    (scale_q.man),
      .res_sign_o (dst_sign[i]),
      .res_exp_o  (dst_exp[i*8 +: 8]),
      .res_man_o  (dst_man[i*23 +: 23]),
      .ovf_o      (lane_ovf_s[i]),
      .unf_o      (lane_unf_s[i])
    );
  end

endmodule

// File: tb/tb_linear_dequant_pipe.sv
// Randomised self-checking bench for linear_dequant_pipe against a
// plain-arithmetic FP32 multiply model and an in-order expected-beat queue.
module tb_linear_dequant_pipe;

  localparam int LANES = 8;
  localparam int CNT_W = 32;
  localparam int DW    = LANES * 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, mode, scale_wr, scale_sign, src_valid, src_ready;
  logic [22:0]         scale_man;
  logic [7:0]          scale_exp;
  logic [LANES*23-1:0] src_man, dst_man;
  logic [LANES*8-1:0]  src_exp, dst_exp;
  logic [LANES-1:0]    src_sign, dst_sign;
  logic                dst_valid, dst_ready, clr_flags, ovf_flag, unf_flag;
  logic [CNT_W-1:0]    beat_cnt;

  linear_dequant_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .scale_wr(scale_wr),
    .scale_man(scale_man), .scale_exp(scale_exp), .scale_sign(scale_sign),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_man(src_man), .src_exp(src_exp), .src_sign(src_sign),
    .dst_valid(dst_valid), .dst_ready(dst_ready),
    .dst_man(dst_man), .dst_exp(dst_exp), .dst_sign(dst_sign),
    .clr_flags(clr_flags), .ovf_flag(ovf_flag), .unf_flag(unf_flag),
    .beat_cnt(beat_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference model state
  logic [DW+1:0]    exp_q[$];
  logic [DW-1:0]    last_data;
  logic [31:0]      scale_m;
  logic             ovf_m, unf_m, last_acc;
  logic [CNT_W-1:0] cnt_m;

  // Returns {ovf, unf, sign, exp, man} for one lane.
  function automatic logic [33:0] ref_mul(logic [31:0] a, logic [31:0] b, logic md);
    int unsigned ea, eb;
    int          e;
    logic [22:0] ma, mb, m;
    logic        s, an, bn, ai, bi, az, bz;
    logic [63:0] p;
    if (md) return {2'b00, a};
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    ma = a[22:0];        mb = b[22:0];
    s  = a[31] ^ b[31];
    an = (ea == 255) && (ma != 23'd0); bn = (eb == 255) && (mb != 23'd0);
    ai = (ea == 255) && (ma == 23'd0); bi = (eb == 255) && (mb == 23'd0);
    az = (ea == 0);                    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {2'b00, 1'b0, 8'hFF, 23'h400000};
    if (ea == 255 || eb == 255) return {2'b00, s, 8'hFF, 23'h0};
    if (az || bz) return {2'b00, s, 31'h0};
    p = (64'h800000 | 64'(ma)) * (64'h800000 | 64'(mb));
    if (p >= 64'h8000_0000_0000) begin
      m = 23'(p >> 24);
      e = int'(ea + eb) - 126;
    end else begin
      m = 23'(p >> 23);
      e = int'(ea + eb) - 127;
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
    if (e <= 0)   return {2'b01, s, 31'h0};
    return {2'b00, s, 8'(e), m};
  endfunction

  function automatic logic [DW+1:0] ref_beat(logic [31:0] sc, logic md);
    logic [DW+1:0] r;
    logic [33:0]   l;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      l = ref_mul({src_sign[i], src_exp[i*8 +: 8], src_man[i*23 +: 23]}, sc, md);
      r[i*32 +: 32] = l[31:0];
      r[DW+1] = r[DW+1] | l[33];
      r[DW]   = r[DW]   | l[32];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] obs_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[i*32 +: 32] = {dst_sign[i], dst_exp[i*8 +: 8], dst_man[i*23 +: 23]};
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m;
    m = 23'($urandom);
    case ($urandom_range(0, 9))
      0: e = 8'd0;
      1: begin e = 8'd255; if ($urandom_range(0, 1) == 0) m = 23'd0; end
      2: e = 8'($urandom_range(200, 254));
      3: e = 8'($urandom_range(1, 60));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, m};
  endfunction

  task automatic set_lane(int i, logic [31:0] v);
    src_sign[i]         = v[31];
    src_exp[i*8 +: 8]   = v[30:23];
    src_man[i*23 +: 23] = v[22:0];
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < LANES; i++) set_lane(i, rand_fp());
  endtask

  task automatic all_lanes(logic [31:0] v);
    for (int i = 0; i < LANES; i++) set_lane(i, v);
  endtask

  task automatic set_scale(logic [31:0] v);
    scale_wr = 1'b1; scale_sign = v[31]; scale_exp = v[30:23]; scale_man = v[22:0];
  endtask

  task automatic idle();
    src_valid = 1'b0; scale_wr = 1'b0; clr_flags = 1'b0; dst_ready = 1'b1; mode = 1'b0;
  endtask

  // One clock: model acceptance, then check output beat, flags and counter.
  task automatic step();
    logic adv_p;
    logic [DW+1:0] e;
    #1;
    adv_p    = src_ready;
    last_acc = src_valid && adv_p && !rst;
    if (last_acc) exp_q.push_back(ref_beat(scale_m, mode));
    if (!rst && scale_wr) scale_m = {scale_sign, scale_exp, scale_man};
    @(posedge clk); #1;
    if (rst) begin
      exp_q.delete();
      cnt_m = '0; ovf_m = 1'b0; unf_m = 1'b0; scale_m = 32'h3F800000;
      check_eq("rst_valid", DW'(dst_valid), DW'(1'b0));
    end else begin
      if (clr_flags) cnt_m = '0;
      else if (last_acc) cnt_m = cnt_m + 1;
      if (adv_p && dst_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("stale_beat", DW'(1'b1), DW'(1'b0));
        end else begin
          e = exp_q.pop_front();
          last_data = e[DW-1:0];
          check_eq("data", obs_beat(), e[DW-1:0]);
          ovf_m = ovf_m | e[DW+1];
          unf_m = unf_m | e[DW];
        end
      end else if (dst_valid) begin
        check_eq("hold", obs_beat(), last_data);
      end
      if (clr_flags) begin ovf_m = 1'b0; unf_m = 1'b0; end
    end
    check_eq("ovf", DW'(ovf_flag), DW'(ovf_m));
    check_eq("unf", DW'(unf_flag), DW'(unf_m));
    check_eq("cnt", DW'(beat_cnt), DW'(cnt_m));
  endtask

  task automatic drain();
    idle();
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) step();
    step();
    check_eq("drain", DW'(exp_q.size()), DW'(0));
  endtask

  // Send one beat and step until it is presented at the outputs.
  task automatic send_and_wait(logic md);
    mode = md; src_valid = 1'b1;
    step();
    check_eq("lat1", DW'(dst_valid), DW'(1'b0));
    idle();
    step();
    check_eq("lat2", DW'(dst_valid), DW'(1'b0));
    step();
    check_eq("lat3", DW'(dst_valid), DW'(1'b1));
  endtask

  task automatic clr_step();
    idle(); clr_flags = 1'b1; step(); clr_flags = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent;
    idle();
    scale_man = 23'd0; scale_exp = 8'd0; scale_sign = 1'b0;
    all_lanes(32'h0);
    last_data = '0; cnt_m = '0; ovf_m = 1'b0; unf_m = 1'b0; scale_m = 32'h3F800000;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_eq("rst_man",  DW'(dst_man),  DW'(1'b0));
    check_eq("rst_exp",  DW'(dst_exp),  DW'(1'b0));
    check_eq("rst_sign", DW'(dst_sign), DW'(1'b0));
    dst_ready = 1'b0; #1;
    check_eq("rst_rdy", DW'(src_ready), DW'(1'b1));
    dst_ready = 1'b1;

    // Basic: 1.5 * 2.0 = 3.0 on lane 0, random normals elsewhere
    set_scale(32'h40000000); step(); idle();
    for (int i = 1; i < LANES; i++) set_lane(i, {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)});
    set_lane(0, 32'h3FC00000);
    send_and_wait(1'b0);
    check_eq("basic_exp", DW'(dst_exp[7:0]), DW'(8'd128));
    check_eq("basic_man", DW'(dst_man[22:0]), DW'(23'h400000));
    drain();

    // Denormal input flushes to signed zero
    set_lane(0, {1'b1, 8'd0, 23'd5});
    send_and_wait(1'b0);
    check_eq("denorm", DW'({dst_sign[0], dst_exp[7:0], dst_man[22:0]}), DW'({1'b1, 31'h0}));
    drain();

    // Overflow then underflow
    clr_step();
    set_scale({1'b0, 8'd254, 23'd0}); step(); idle();
    all_lanes({1'b0, 8'd254, 23'h123});
    send_and_wait(1'b0); drain();
    check_eq("ovf_set", DW'(ovf_flag), DW'(1'b1));
    clr_step();
    set_scale({1'b0, 8'd1, 23'd0}); step(); idle();
    all_lanes({1'b1, 8'd1, 23'h7});
    send_and_wait(1'b0); drain();
    check_eq("unf_set", DW'(unf_flag), DW'(1'b1));
    check_eq("unf_noovf", DW'(ovf_flag), DW'(1'b0));

    // Zero x inf -> quiet NaN
    set_scale({1'b1, 8'd255, 23'd0}); step(); idle();
    all_lanes(32'h0);
    send_and_wait(1'b0);
    check_eq("nan", DW'({dst_sign[0], dst_exp[7:0], dst_man[22:0]}), DW'({1'b0, 8'hFF, 23'h400000}));
    drain();

    // Bypass with would-overflow lanes
    clr_step();
    set_scale({1'b0, 8'd254, 23'd0}); step(); idle();
    for (int i = 0; i < LANES; i++) set_lane(i, {1'($urandom), 8'd254, 23'($urandom)});
    send_and_wait(1'b1); drain();
    check_eq("byp_ovf", DW'(ovf_flag), DW'(1'b0));
    check_eq("byp_unf", DW'(unf_flag), DW'(1'b0));

    // clr_flags in the cycle an overflow beat enters the output stage
    src_valid = 1'b1; step(); idle();
    step();
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    check_eq("clr_ovf", DW'(ovf_flag), DW'(1'b0));
    drain();

    // Scale change in the same cycle as beat k
    set_scale(32'h40000000); step(); idle();
    all_lanes(32'h3F800000);
    src_valid = 1'b1; set_scale(32'h40800000); step();
    scale_wr = 1'b0; step(); step();
    check_eq("scl_old", DW'(dst_exp[7:0]), DW'(8'd128));
    step();
    check_eq("scl_new", DW'(dst_exp[7:0]), DW'(8'd129));
    drain();

    // Backpressure: 20 beats with a stall window
    clr_step();
    sent = 0;
    for (int c = 0; c < 60 && sent < 20; c++) begin
      rand_lanes(); mode = 1'($urandom_range(0, 3) == 0);
      src_valid = 1'b1;
      dst_ready = (c >= 5 && c <= 9) ? 1'b0 : 1'b1;
      #1;
      if (c >= 5 && c <= 9) check_eq("stall_rdy", DW'(src_ready), DW'(1'b0));
      step();
      if (last_acc) sent++;
    end
    drain();
    check_eq("bp_cnt", DW'(beat_cnt), DW'(20));

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rand_lanes();
      mode      = 1'($urandom_range(0, 4) == 0);
      src_valid = 1'($urandom_range(0, 9) < 7);
      dst_ready = 1'($urandom_range(0, 9) < 7);
      scale_wr  = 1'b0;
      if ($urandom_range(0, 19) == 0) set_scale(rand_fp());
      step();
    end
    drain();

    // Reset with three beats in flight
    set_scale(32'h40800000); step(); idle();
    all_lanes(32'h3F800000);
    src_valid = 1'b1; step(); step(); step();
    idle(); rst = 1'b1; step(); rst = 1'b0;
    check_eq("rst_cnt", DW'(beat_cnt), DW'(0));
    all_lanes(32'h3F800000);
    send_and_wait(1'b0);
    check_eq("rst_scale", DW'(dst_exp[7:0]), DW'(8'd127));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
